// File: rtl/mc_pkg.sv
// mc_pkg
// Shared encodings for the multi-cycle ARM datapath and its controller's decoder.
//   RESULT_*  : ResultSrc encodings for the result bus mux
//   IMM_*     : ImmSrc encodings for the immediate extender
//   REG_PC    : register address that aliases the PC (R15)
//   NUM_REGS  : number of stored general registers (R0-R14)
//   extend_imm: immediate extension shared by datapath and decoder
package mc_pkg;

    localparam logic [1:0] RESULT_ALUOUT = 2'b00;
    localparam logic [1:0] RESULT_DATA   = 2'b01;
    localparam logic [1:0] RESULT_ALU    = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_BR = 2'b10;

    localparam logic [3:0] REG_PC   = 4'd15;
    localparam int         NUM_REGS = 15;

    // Branch offsets are word offsets, hence the two appended zero bits
    // before sign extension.
    function automatic logic [31:0] extend_imm(input logic [1:0]  src,
                                               input logic [23:0] field);
        logic [31:0] imm;
        imm = 32'h0;
        case (src)
            IMM_8:   imm = {24'h0, field[7:0]};
            IMM_12:  imm = {20'h0, field[11:0]};
            IMM_BR:  imm = {{6{field[23]}}, field, 2'b00};
            default: imm = 32'h0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_datapath_regs_if.sv
// mc_datapath_regs_if
// Bus between the controller/memory side and the state-holding datapath.
//   Control in : PCWrite, IRWrite, RegWrite, AdrSrc, RegSrc[1:0],
//                ResultSrc[1:0], ImmSrc[1:0]
//   Data in    : ALUResult[31:0] (ALU output), ReadData[31:0] (memory)
//   Out        : Adr, Instr, RegA, WriteData, ExtImm, PC, Result (32 bits each)
// master = controller/memory side, slave = datapath.
interface mc_datapath_regs_if;

    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [31:0] ALUResult;
    logic [31:0] ReadData;

    logic [31:0] Adr;
    logic [31:0] Instr;
    logic [31:0] RegA;
    logic [31:0] WriteData;
    logic [31:0] ExtImm;
    logic [31:0] PC;
    logic [31:0] Result;

    modport master (
        output PCWrite, IRWrite, RegWrite, AdrSrc, RegSrc, ResultSrc, ImmSrc,
        output ALUResult, ReadData,
        input  Adr, Instr, RegA, WriteData, ExtImm, PC, Result
    );

    modport slave (
        input  PCWrite, IRWrite, RegWrite, AdrSrc, RegSrc, ResultSrc, ImmSrc,
        input  ALUResult, ReadData,
        output Adr, Instr, RegA, WriteData, ExtImm, PC, Result
    );

endinterface

// File: rtl/mc_regfile.sv
// mc_regfile
// R0-R14 storage with two combinational read ports and one write port.
//   clk, reset : clock, asynchronous active-high clear of all registers
//   we, wa, wd : write enable, write address, write data
//   ra1, ra2   : read addresses
//   r15        : value returned for reads of address 15
//   rd1, rd2   : read data
module mc_regfile
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  wa,
    input  logic [31:0] wd,
    input  logic [3:0]  ra1,
    input  logic [3:0]  ra2,
    input  logic [31:0] r15,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] mem [NUM_REGS];

    // Address 15 is the PC alias and has no storage, so writes to it drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i[3:0]] <= 32'h0;
            end
        end else if (we && (wa != REG_PC)) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == REG_PC) ? r15 : mem[ra1];
    assign rd2 = (ra2 == REG_PC) ? r15 : mem[ra2];

endmodule

// File: rtl/mc_datapath_regs.sv
// mc_datapath_regs
// State-holding half of the multi-cycle ARM datapath: PC, IR, register file
// and the Data/A/B/ALUOut staging registers, plus the result, address and
// immediate muxes.
//   clk   : rising-edge clock
//   reset : asynchronous active-high, clears all state
//   bus   : mc_datapath_regs_if.slave (controls, ALUResult, ReadData in;
//           Adr, Instr, RegA, WriteData, ExtImm, PC, Result out)
// Parameter RESET_PC: value the PC takes on reset.
module mc_datapath_regs
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    mc_datapath_regs_if.slave     bus
);

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] data;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_out;

    logic [31:0] result;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [3:0]  ra1;
    logic [3:0]  ra2;

    always_comb begin
        result = bus.ALUResult;
        case (bus.ResultSrc)
            RESULT_ALUOUT: result = alu_out;
            RESULT_DATA:   result = data;
            RESULT_ALU:    result = bus.ALUResult;
            default:       result = bus.ALUResult;
        endcase
    end

    assign ra1 = bus.RegSrc[0] ? REG_PC : ir[19:16];
    assign ra2 = bus.RegSrc[1] ? ir[15:12] : ir[3:0];

    // Reads of R15 see the live result bus, which carries PC+8 in the
    // controller's sequencing.
    mc_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (bus.RegWrite),
        .wa    (ir[15:12]),
        .wd    (result),
        .ra1   (ra1),
        .ra2   (ra2),
        .r15   (result),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // During fetch IR takes ReadData addressed by the old PC while PC
    // updates on the same edge; A/B see the pre-write register value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= 32'h0;
            data    <= 32'h0;
            a       <= 32'h0;
            b       <= 32'h0;
            alu_out <= 32'h0;
        end else begin
            if (bus.PCWrite) pc <= result;
            if (bus.IRWrite) ir <= bus.ReadData;
            data    <= bus.ReadData;
            a       <= rd1;
            b       <= rd2;
            alu_out <= bus.ALUResult;
        end
    end

    // AdrSrc=1 with ResultSrc=ALU forms a combinational ALUResult->Adr path;
    // the controller never selects it, so it is left unblocked.
    assign bus.Adr       = bus.AdrSrc ? result : pc;
    assign bus.Result    = result;
    assign bus.Instr     = ir;
    assign bus.RegA      = a;
    assign bus.WriteData = b;
    assign bus.PC        = pc;
    assign bus.ExtImm    = extend_imm(bus.ImmSrc, ir[23:0]);

endmodule

// File: tb/tb_mc_datapath_regs.sv
module tb_mc_datapath_regs;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic reset;

    mc_datapath_regs_if bus();

    mc_datapath_regs #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference state
    logic [31:0] m_pc, m_ir, m_data, m_a, m_b, m_aluout;
    logic [31:0] m_rf [15];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = RST_PC; m_ir = 0; m_data = 0; m_a = 0; m_b = 0; m_aluout = 0;
        for (int i = 0; i < 15; i++) m_rf[i] = 0;
    endtask

    function automatic logic [31:0] m_result();
        if (bus.ResultSrc == 2'b00) return m_aluout;
        if (bus.ResultSrc == 2'b01) return m_data;
        return bus.ALUResult;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] ra);
        if (ra == 4'd15) return m_result();
        return m_rf[ra];
    endfunction

    function automatic logic [31:0] m_imm();
        logic [23:0] f;
        f = m_ir[23:0];
        case (bus.ImmSrc)
            2'b00:   return {24'h0, f[7:0]};
            2'b01:   return {20'h0, f[11:0]};
            2'b10:   return {{6{f[23]}}, f, 2'b00};
            default: return 32'h0;
        endcase
    endfunction

    task automatic apply(input logic pcw, input logic irw, input logic rw, input logic as,
                         input logic [1:0] rgs, input logic [1:0] rss, input logic [1:0] ims,
                         input logic [31:0] alu, input logic [31:0] rdat);
        bus.PCWrite = pcw; bus.IRWrite = irw; bus.RegWrite = rw; bus.AdrSrc = as;
        bus.RegSrc = rgs; bus.ResultSrc = rss; bus.ImmSrc = ims;
        bus.ALUResult = alu; bus.ReadData = rdat;
        #1;
    endtask

    task automatic check_all();
        chk("Result", bus.Result, m_result());
        chk("Adr", bus.Adr, bus.AdrSrc ? m_result() : m_pc);
        chk("ExtImm", bus.ExtImm, m_imm());
        chk("Instr", bus.Instr, m_ir);
        chk("RegA", bus.RegA, m_a);
        chk("WriteData", bus.WriteData, m_b);
        chk("PC", bus.PC, m_pc);
    endtask

    task automatic tick();
        logic [31:0] res, n1, n2;
        logic [3:0]  rd;
        res = m_result();
        n1  = m_read(bus.RegSrc[0] ? 4'd15 : m_ir[19:16]);
        n2  = m_read(bus.RegSrc[1] ? m_ir[15:12] : m_ir[3:0]);
        rd  = m_ir[15:12];
        @(posedge clk);
        if (bus.RegWrite && rd != 4'd15) m_rf[rd] = res;
        if (bus.PCWrite) m_pc = res;
        if (bus.IRWrite) m_ir = bus.ReadData;
        m_data = bus.ReadData; m_a = n1; m_b = n2; m_aluout = bus.ALUResult;
        #1;
    endtask

    task automatic step(input logic pcw, input logic irw, input logic rw, input logic as,
                        input logic [1:0] rgs, input logic [1:0] rss, input logic [1:0] ims,
                        input logic [31:0] alu, input logic [31:0] rdat);
        apply(pcw, irw, rw, as, rgs, rss, ims, alu, rdat);
        check_all();
        tick();
    endtask

    // Reset asserted between edges with enables active.
    task automatic mid_reset();
        apply(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, $urandom, $urandom);
        reset = 1'b1;
        #1;
        m_reset();
        chk("rst_pc", bus.PC, RST_PC);
        chk("rst_instr", bus.Instr, 32'h0);
        chk("rst_rega", bus.RegA, 32'h0);
        chk("rst_wdata", bus.WriteData, 32'h0);
        @(posedge clk);
        #1;
        check_all();
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        apply(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
        m_reset();
        chk("init_pc", bus.PC, RST_PC);
        chk("init_instr", bus.Instr, 32'h0);
        check_all();
        #11;
        reset = 1'b0;

        // Fetch
        step(1, 1, 0, 0, 2'b00, 2'b10, 2'b00, 32'h4, 32'hE3A01005);
        chk("fetch_instr", bus.Instr, 32'hE3A01005);
        chk("fetch_pc", bus.PC, 32'h4);

        // Writeback R1 = 5, then read it through A
        step(0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 32'h5, 32'h0);
        step(0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0001_0000);
        step(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0);
        chk("wb_rega", bus.RegA, 32'h5);

        // R15 read returns Result
        step(0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 32'h108, 32'h0);
        chk("r15_rega", bus.RegA, 32'h108);

        // Write to Rd=15 is dropped
        step(0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0000_F000);
        step(0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 32'hDEAD_BEEF, 32'h0);

        // Same-edge read/write of R2: A sees old value first
        step(0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0002_2000);
        step(0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 32'h55, 32'h0);
        chk("nobypass_old", bus.RegA, 32'h0);
        step(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0);
        chk("nobypass_new", bus.RegA, 32'h55);

        // Sweep R0-R14
        for (int r = 0; r < 15; r++) begin
            logic [31:0] w;
            w = 32'(r) << 16;
            step(0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 32'h0, w);
            step(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0);
            chk($sformatf("rf_r%0d", r), bus.RegA,
                (r == 1) ? 32'h5 : ((r == 2) ? 32'h55 : 32'h0));
        end

        // Immediates
        step(0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 32'h0, 32'h00FF_FFFE);
        apply(0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 32'h0, 32'h0);
        chk("imm_br", bus.ExtImm, 32'hFFFF_FFF8);
        step(0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0000_0ABC);
        apply(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 32'h0, 32'h0);
        chk("imm_12", bus.ExtImm, 32'h0000_0ABC);
        apply(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 32'h0, 32'h0);
        chk("imm_8", bus.ExtImm, 32'h0000_00BC);
        apply(0, 0, 0, 0, 2'b00, 2'b10, 2'b11, 32'h0, 32'h0);
        chk("imm_zero", bus.ExtImm, 32'h0);

        // Load path
        step(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 32'h40, 32'h0);
        apply(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 32'h77, 32'h1234);
        chk("load_adr", bus.Adr, 32'h40);
        check_all();
        tick();
        apply(0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 32'h0, 32'h0);
        chk("load_result", bus.Result, 32'h1234);
        apply(0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 32'h9999, 32'h0);
        chk("result_rsvd", bus.Result, 32'h9999);

        // Randomized traffic with occasional mid-cycle reset
        for (int i = 0; i < 400; i++) begin
            if ((i % 57) == 56) begin
                mid_reset();
            end else begin
                step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     2'($urandom), 2'($urandom), 2'($urandom), $urandom, $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
